pit_ctrl: RTL
=============

PIT_CTRL -- requirements
Module: pit_ctrl

Interface
REQ-001 The block SHALL have no parameters; it SHALL serve three 16-bit counters, indexed 0..2.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cs  input  1  chip select, active-high; when cs=0, wr and rd SHALL be ignored.
REQ-005 wr  input  1  write strobe, one-cycle pulse.
REQ-006 rd  input  1  read strobe, one-cycle pulse.
REQ-007 a  input  2  register address: 0..2 select counter data ports; 3 selects the control word.
REQ-008 din  input  8  write data.
REQ-009 dout  output  8  registered read data.
REQ-010 cnt_value  input  48  current counts; counter i occupies bits [16i+15:16i].
REQ-011 cnt_init  output  48  initial count per counter, in the same packing as cnt_value.
REQ-012 cnt_mode  output  9  mode per counter: 3 bits each, bits [3i+2:3i].
REQ-013 cnt_bcd  output  3  BCD-select flag per counter.
REQ-014 cnt_load  output  3  one-cycle pulse per counter: "new cnt_init valid".

Function
REQ-015 Every access SHALL require cs=1; if wr and rd are both high in the same cycle, wr SHALL take effect and rd SHALL be ignored.
REQ-016 A control-word write (a=3) SHALL decode din as follows:
- SC = din[7:6]
- RW = din[5:4]
- M = din[3:1]
- BCD = din[0]
REQ-017 SC=3 SHALL be a no-op.
REQ-018 RW=00 SHALL be a latch command: snapshot cnt_value[SC] into that counter's output latch and set its latched flag; a latch command while the flag is already set SHALL be ignored; mode and format SHALL be unchanged.
REQ-019 A control word with RW!=00 SHALL:
- store RW, BCD and mode for counter SC;
- store M as written, except M=110 stores 010 and M=111 stores 011;
- reset that counter's write and read byte toggles to LSB;
- clear its latched flag;
- leave cnt_init unchanged.
REQ-020 A data write to counter i SHALL be ignored while its stored RW=00 (the state after reset).
REQ-021 Data writes SHALL depend on the counter's stored RW:
- RW=01: cnt_init[i] <= {8'h00, din}.
- RW=10: cnt_init[i] <= {din, 8'h00}.
- RW=11, first write: hold din as LSB in a staging register and toggle to MSB.
- RW=11, second write: cnt_init[i] <= {din, staged LSB} and toggle back to LSB.
REQ-022 cnt_init[i] SHALL update in the cycle after the completing write.
REQ-023 cnt_load[i] SHALL pulse high for exactly one cycle, coincident with the cnt_init[i] update.
REQ-024 A first LSB write in RW=11 SHALL NOT pulse cnt_load.
REQ-025 A control word rewrite between the LSB and MSB writes SHALL discard the staged LSB.
REQ-026 Reads from counter i SHALL use the latched value if the latched flag is set, otherwise live cnt_value[i].
REQ-027 Read byte selection by RW:
- RW=01: low byte.
- RW=10: high byte.
- RW=11: low byte then high byte, alternating via the read toggle.
- RW=00: 8'h00.
REQ-028 The latched flag SHALL clear after the last byte for the current RW format is read (one read for RW=01/10, the MSB read for RW=11).
REQ-029 The read and write toggles SHALL be independent.
REQ-030 dout SHALL update in the cycle after rd and hold its value otherwise.
REQ-031 A read of a=3 SHALL return 8'h00.
REQ-032 cnt_mode and cnt_bcd SHALL reflect the stored values continuously; a new mode SHALL be visible the cycle after the control-word write.
REQ-033 Writes to different counters SHALL be fully independent; per-counter state SHALL never alias.

Reset
REQ-034 While rst_n=0, asynchronously:
- dout, cnt_init, cnt_mode, cnt_bcd and cnt_load SHALL be 0;
- all stored RW fields SHALL be 00;
- all toggles SHALL be at LSB;
- all latched flags SHALL be clear;
- all staged LSBs SHALL be 0.
REQ-035 Reset asserted between an LSB and MSB write SHALL abandon the sequence; no cnt_load SHALL follow.
REQ-036 The first access SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-037 The bench SHALL cover these scenarios:
- Write ctrl 8'h72, then data 8'h34, 8'h12 to a=1 -> cnt_mode[5:3]=001; cnt_init[31:16]=16'h1234 with one cnt_load[1] pulse, which occurs only after the second byte.
- Write ctrl 8'h14, then data 8'h05 to a=0 -> cnt_init[15:0]=16'h0005 and cnt_load[0] pulses; write ctrl 8'h2C (M=110), then data 8'h07 -> cnt_mode[2:0]=010 and cnt_init[15:0]=16'h0700.
- Set cnt_value[47:32]=16'hABCD, write ctrl 8'hB0 then 8'h80, change cnt_value to 16'h1111, read a=2 twice -> dout reads 8'hCD then 8'hAB; a third read returns 8'h11 (live).
- Write ctrl 8'h30, data 8'h44, then ctrl 8'h30 again, data 8'h55, 8'h66 -> cnt_init[15:0]=16'h6655, exactly one cnt_load[0] pulse.
- Data write to a=2 after reset with no control word, and any access with cs=0 -> no cnt_load, all outputs unchanged; rd and wr together -> write applied, dout unchanged.
- Assert rst_n mid-clock after an LSB write -> outputs clear immediately; a following MSB write is ignored (RW=00).

Source files
------------

// File: rtl/pit_ctrl.sv
// Register interface for a three-counter programmable interval timer:
// decodes control words, assembles initial counts, and serves latched/live count reads.
module pit_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [1:0]  a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [47:0] cnt_value,
  output logic [47:0] cnt_init,
  output logic [8:0]  cnt_mode,
  output logic [2:0]  cnt_bcd,
  output logic [2:0]  cnt_load
);

  logic [2:0][1:0]  rw_q, rw_d;
  logic [2:0][2:0]  mode_q, mode_d;
  logic [2:0][15:0] latch_q, latch_d;
  logic [2:0][15:0] init_q, init_d;
  logic [2:0][7:0]  stage_q, stage_d;
  logic [2:0]       bcd_q, bcd_d;
  logic [2:0]       wtog_q, wtog_d;
  logic [2:0]       rtog_q, rtog_d;
  logic [2:0]       latched_q, latched_d;
  logic [2:0]       load_q, load_d;
  logic [7:0]       dout_q, dout_d;

  logic        wr_en, rd_en;
  logic [2:0]  mode_wr;
  logic [15:0] src;

  // A simultaneous wr/rd is treated as a write only.
  assign wr_en   = cs & wr;
  assign rd_en   = cs & rd & ~wr;
  // Modes 6 and 7 alias onto 2 and 3.
  assign mode_wr = (din[3:2] == 2'b11) ? {1'b0, din[2:1]} : din[3:1];

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latches).
    rw_d      = rw_q;
    mode_d    = mode_q;
    latch_d   = latch_q;
    init_d    = init_q;
    stage_d   = stage_q;
    bcd_d     = bcd_q;
    wtog_d    = wtog_q;
    rtog_d    = rtog_q;
    latched_d = latched_q;
    load_d    = '0;
    dout_d    = dout_q;
    src       = '0;

    for (int i = 0; i < 3; i++) begin
      src = latched_q[i] ? latch_q[i] : cnt_value[16*i +: 16];

      if (wr_en && a == 2'd3 && din[7:6] == 2'(i)) begin
        if (din[5:4] == 2'b00) begin
          if (!latched_q[i]) begin
            latch_d[i]   = cnt_value[16*i +: 16];
            latched_d[i] = 1'b1;
          end
        end else begin
          rw_d[i]      = din[5:4];
          mode_d[i]    = mode_wr;
          bcd_d[i]     = din[0];
          wtog_d[i]    = 1'b0;
          rtog_d[i]    = 1'b0;
          latched_d[i] = 1'b0;
          stage_d[i]   = 8'h00;
        end
      end

      if (wr_en && a == 2'(i)) begin
        unique case (rw_q[i])
          2'b01: begin
            init_d[i] = {8'h00, din};
            load_d[i] = 1'b1;
          end
          2'b10: begin
            init_d[i] = {din, 8'h00};
            load_d[i] = 1'b1;
          end
          2'b11: begin
            if (!wtog_q[i]) begin
              stage_d[i] = din;
              wtog_d[i]  = 1'b1;
            end else begin
              init_d[i] = {din, stage_q[i]};
              load_d[i] = 1'b1;
              wtog_d[i] = 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (rd_en && a == 2'(i)) begin
        unique case (rw_q[i])
          2'b01: begin
            dout_d       = src[7:0];
            latched_d[i] = 1'b0;
          end
          2'b10: begin
            dout_d       = src[15:8];
            latched_d[i] = 1'b0;
          end
          2'b11: begin
            if (!rtog_q[i]) begin
              dout_d    = src[7:0];
              rtog_d[i] = 1'b1;
            end else begin
              dout_d       = src[15:8];
              rtog_d[i]    = 1'b0;
              latched_d[i] = 1'b0;
            end
          end
          default: dout_d = 8'h00;
        endcase
      end
    end

    if (rd_en && a == 2'd3) dout_d = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-counter register arrays are tiny flop banks, not RAMs, so they are reset like any other state.
      rw_q      <= '0;
      mode_q    <= '0;
      latch_q   <= '0;
      init_q    <= '0;
      stage_q   <= '0;
      bcd_q     <= '0;
      wtog_q    <= '0;
      rtog_q    <= '0;
      latched_q <= '0;
      load_q    <= '0;
      dout_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge next-state values.
      rw_q      <= rw_d;
      mode_q    <= mode_d;
      latch_q   <= latch_d;
      init_q    <= init_d;
      stage_q   <= stage_d;
      bcd_q     <= bcd_d;
      wtog_q    <= wtog_d;
      rtog_q    <= rtog_d;
      latched_q <= latched_d;
      load_q    <= load_d;
      dout_q    <= dout_d;
    end
  end

  assign dout     = dout_q;
  assign cnt_init = init_q;
  assign cnt_mode = mode_q;
  assign cnt_bcd  = bcd_q;
  assign cnt_load = load_q;

endmodule
